// File: rtl/gpio_in_cond.sv
// Purpose  : GPIO input conditioner with a Wishbone slave register block. It synchronises,
//            debounces and edge-detects 8 pad inputs and raises a sticky, maskable interrupt.
// Latency  : a pad level that is stable from sampling edge E appears on GPIO_IN_o after edge
//            E+1+max(DB_LIMIT,1), or after E+2 without debounce. INT_STAT sets one cycle after
//            the filtered edge, and IRQ_o follows one cycle later.
// Backpress: the bus ack is one registered pulse per strobe. Back-to-back strobes are acked
//            every other cycle. The pad path has no backpressure.
//
// Ports:
//   WBs_CLK_i, WBs_RST_i   : the only clock (rising edge) and a synchronous active-high reset
//   WBs_ADR_i .. WBs_DAT_i : Wishbone slave inputs (only byte 0 of write data is used)
//   WBs_DAT_o, WBs_ACK_o   : read data (combinational from WBs_ADR_i) and the registered ack
//   GPIO_PAD_i             : raw asynchronous pad inputs
//   GPIO_IN_o              : conditioned (filtered) levels
//   IRQ_o                  : registered OR of INT_STAT
//
// Optional feature: define GPIO_IN_COND_DEBOUNCE_EN to build the per-bit debounce counters
// and the DB_LIMIT register. Without it, filt follows sync1 every cycle and DB_LIMIT reads 0.
//
// Register map (word addresses):
//   0x00 LEVEL RO | 0x01 INT_EN RW | 0x02 INT_POL RW | 0x03 INT_STAT RO/W1C
//   0x04 DB_LIMIT RW | 0x05 RAW RO | other addresses: DEF_REG_VALUE

module gpio_in_cond #(
   parameter int          ADDRWIDTH     = 7,
   parameter int          DATAWIDTH     = 32,
   parameter logic [7:0]  DB_LIMIT_RST  = 8'h04,
   parameter logic [31:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
   input  logic                 WBs_CLK_i,
   input  logic                 WBs_RST_i,
   input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
   input  logic                 WBs_CYC_i,
   input  logic [3:0]           WBs_BYTE_STB_i,
   input  logic                 WBs_WE_i,
   input  logic                 WBs_STB_i,
   input  logic [DATAWIDTH-1:0] WBs_DAT_i,
   output logic [DATAWIDTH-1:0] WBs_DAT_o,
   output logic                 WBs_ACK_o,
   input  logic [7:0]           GPIO_PAD_i,
   output logic [7:0]           GPIO_IN_o,
   output logic                 IRQ_o
);

   localparam logic [ADDRWIDTH-1:0] ADR_LEVEL    = ADDRWIDTH'(0);
   localparam logic [ADDRWIDTH-1:0] ADR_INT_EN   = ADDRWIDTH'(1);
   localparam logic [ADDRWIDTH-1:0] ADR_INT_POL  = ADDRWIDTH'(2);
   localparam logic [ADDRWIDTH-1:0] ADR_INT_STAT = ADDRWIDTH'(3);
   localparam logic [ADDRWIDTH-1:0] ADR_DB_LIMIT = ADDRWIDTH'(4);
   localparam logic [ADDRWIDTH-1:0] ADR_RAW      = ADDRWIDTH'(5);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [7:0] r_sync0;
   logic [7:0] r_sync1;
   logic [7:0] r_filt;
   logic [7:0] r_filt_d;
   logic [7:0] r_int_en;
   logic [7:0] r_int_pol;
   logic [7:0] r_int_stat;
   logic       r_ack;
   logic       r_irq;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic       w_bus_req;
   logic       w_wr;
   logic       w_wr_int_en;
   logic       w_wr_int_pol;
   logic       w_wr_int_stat;
   logic       w_wr_db_limit;
   logic [7:0] w_wr_byte;
   logic [7:0] w_db_limit;

   // The ~r_ack term stops a strobe that is still held during its ack cycle from being
   // taken a second time. It also produces the every-other-cycle ack cadence.
   assign w_bus_req     = WBs_CYC_i & WBs_STB_i & ~r_ack;
   assign w_wr          = w_bus_req & WBs_WE_i & WBs_BYTE_STB_i[0];
   assign w_wr_byte     = WBs_DAT_i[7:0];
   assign w_wr_int_en   = w_wr & (WBs_ADR_i == ADR_INT_EN);
   assign w_wr_int_pol  = w_wr & (WBs_ADR_i == ADR_INT_POL);
   assign w_wr_int_stat = w_wr & (WBs_ADR_i == ADR_INT_STAT);
   assign w_wr_db_limit = w_wr & (WBs_ADR_i == ADR_DB_LIMIT);

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= w_bus_req;
      end
   end

   assign WBs_ACK_o = r_ack;

   // ------------------------------------------------------------------
   // Pad synchroniser (two flops per bit)
   // ------------------------------------------------------------------
   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_sync0 <= 8'h00;
         r_sync1 <= 8'h00;
      end else begin
         r_sync0 <= GPIO_PAD_i;
         r_sync1 <= r_sync0;
      end
   end

   // ------------------------------------------------------------------
   // Debounce filter
   // ------------------------------------------------------------------
`ifdef GPIO_IN_COND_DEBOUNCE_EN
   logic [7:0]      r_db_limit;
   logic [7:0][7:0] r_cnt;
   logic            w_unused;

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_db_limit <= DB_LIMIT_RST;
      end else if (w_wr_db_limit) begin
         r_db_limit <= w_wr_byte;
      end
   end

   assign w_db_limit = r_db_limit;

   // Each bit counts the consecutive cycles in which sync1 disagrees with filt.
   // Any agreement (a glitch that ends early) drops the count back to zero.
   // The compare is done 9 bits wide so that count+1 cannot wrap. Because it is a
   // ">=" compare, a count that is already past a newly lowered limit commits on
   // the next cycle in which the bit still differs.
   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_filt <= 8'h00;
         r_cnt  <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (r_sync1[i] != r_filt[i]) begin
               if (({1'b0, r_cnt[i]} + 9'd1) >= {1'b0, r_db_limit}) begin
                  r_filt[i] <= r_sync1[i];
                  r_cnt[i]  <= 8'd0;
               end else begin
                  r_cnt[i]  <= r_cnt[i] + 8'd1;
               end
            end else begin
               r_cnt[i] <= 8'd0;
            end
         end
      end
   end

   assign w_unused = ^{WBs_DAT_i[DATAWIDTH-1:8], WBs_BYTE_STB_i[3:1]};
`else
   logic w_unused;

   // Without debounce there is no limit register. Writes to DB_LIMIT are dropped.
   assign w_db_limit = 8'h00;

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_filt <= 8'h00;
      end else begin
         r_filt <= r_sync1;
      end
   end

   assign w_unused = ^{WBs_DAT_i[DATAWIDTH-1:8], WBs_BYTE_STB_i[3:1],
                       DB_LIMIT_RST, w_wr_db_limit};
`endif

   assign GPIO_IN_o = r_filt;

   // ------------------------------------------------------------------
   // Edge detection and interrupt status
   // ------------------------------------------------------------------
   logic [7:0] w_rise;
   logic [7:0] w_fall;
   logic [7:0] w_set;
   logic [7:0] w_clr;

   assign w_rise = r_filt & ~r_filt_d;
   assign w_fall = ~r_filt & r_filt_d;
   assign w_set  = r_int_en & ((r_int_pol & w_rise) | (~r_int_pol & w_fall));
   assign w_clr  = w_wr_int_stat ? w_wr_byte : 8'h00;

   always_ff @(posedge WBs_CLK_i) begin
      if (WBs_RST_i) begin
         r_filt_d   <= 8'h00;
         r_int_en   <= 8'h00;
         r_int_pol  <= 8'h00;
         r_int_stat <= 8'h00;
         r_irq      <= 1'b0;
      end else begin
         r_filt_d <= r_filt;
         if (w_wr_int_en) begin
            r_int_en <= w_wr_byte;
         end
         if (w_wr_int_pol) begin
            r_int_pol <= w_wr_byte;
         end
         // The set term is ORed in after the clear, so a new edge is never lost
         // to a W1C that lands in the same cycle. Disabling INT_EN leaves
         // pending bits alone.
         r_int_stat <= (r_int_stat & ~w_clr) | w_set;
         r_irq      <= |r_int_stat;
      end
   end

   assign IRQ_o = r_irq;

   // ------------------------------------------------------------------
   // Read mux (combinational from the address)
   // ------------------------------------------------------------------
   function automatic logic [DATAWIDTH-1:0] zext8(input logic [7:0] v);
      return {{(DATAWIDTH-8){1'b0}}, v};
   endfunction

   logic [DATAWIDTH-1:0] w_rd_dat;

   always_comb begin
      w_rd_dat = DATAWIDTH'(DEF_REG_VALUE);
      case (WBs_ADR_i)
         ADR_LEVEL:    w_rd_dat = zext8(r_filt);
         ADR_INT_EN:   w_rd_dat = zext8(r_int_en);
         ADR_INT_POL:  w_rd_dat = zext8(r_int_pol);
         ADR_INT_STAT: w_rd_dat = zext8(r_int_stat);
         ADR_DB_LIMIT: w_rd_dat = zext8(w_db_limit);
         ADR_RAW:      w_rd_dat = zext8(r_sync1);
         default:      w_rd_dat = DATAWIDTH'(DEF_REG_VALUE);
      endcase
   end

   assign WBs_DAT_o = w_rd_dat;

endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
Parameters
- REQ-001 SHALL have parameter ADDRWIDTH, default 7, giving the Wishbone address width.
- REQ-002 SHALL have parameter DATAWIDTH, default 32, giving the Wishbone data width.
- REQ-003 SHALL have parameter DB_LIMIT_RST, default 8'h04, giving the reset value of the debounce limit.
- REQ-004 SHALL have parameter DEF_REG_VALUE, default 32'hFAB_DEF_AC, returned on reads of unmapped addresses.

Ports
- REQ-005 SHALL have port WBs_CLK_i, input, 1 bit: the only clock. All logic is on its rising edge.
- REQ-006 SHALL have port WBs_RST_i, input, 1 bit: reset, synchronous and active-high.
- REQ-007 SHALL have Wishbone slave inputs:
  - WBs_ADR_i [ADDRWIDTH], WBs_CYC_i 1, WBs_BYTE_STB_i 4, WBs_WE_i 1, WBs_STB_i 1, WBs_DAT_i [DATAWIDTH].
- REQ-008 SHALL have Wishbone slave outputs:
  - WBs_DAT_o [DATAWIDTH]: read data.
  - WBs_ACK_o 1: acknowledge.
- REQ-009 SHALL have port GPIO_PAD_i, input, 8 bits: raw asynchronous pad inputs.
- REQ-010 SHALL have port GPIO_IN_o, output, 8 bits: conditioned levels, feeding the register block's GPIO_IN_i.
- REQ-011 SHALL have port IRQ_o, output, 1 bit: registered interrupt request.

Function
- REQ-012 SHALL pass each GPIO_PAD_i bit through a 2-flop synchronizer, sync0 then sync1.
- REQ-013 SHALL debounce each bit independently with an 8-bit counter:
  - if sync1 != filt: count increments;
  - when count+1 >= DB_LIMIT: filt <= sync1 and count <= 0;
  - if sync1 == filt: count <= 0.
- REQ-014 SHALL give pad-to-output latency as follows: a pad level stable from sampling edge E appears on GPIO_IN_o after edge E+1+max(DB_LIMIT,1).
- REQ-015 SHALL drive GPIO_IN_o from the filt register.
- REQ-016 SHALL detect edges per bit from filt and filt_d (filt delayed one cycle):
  - rise = filt & ~filt_d;
  - fall = ~filt & filt_d.
- REQ-017 SHALL set INT_STAT[i] on the cycle after the selected edge when INT_EN[i]=1:
  - INT_POL[i]=1 selects rise;
  - INT_POL[i]=0 selects fall.
- REQ-018 SHALL keep INT_STAT bits sticky until cleared by a write-1-to-clear; if a set and a clear hit the same bit in the same cycle, the set wins.
- REQ-019 SHALL register IRQ_o as IRQ_o <= |INT_STAT, so it follows INT_STAT by one cycle.
- REQ-020 SHALL NOT clear pending INT_STAT bits when INT_EN bits are cleared.
- REQ-021 SHALL compute ack as ack_nxt = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o, registered. This gives single-cycle ack pulses, with back-to-back strobes acked every other cycle.
- REQ-022 SHALL qualify writes with WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~WBs_ACK_o & WBs_BYTE_STB_i[0]; only byte 0 is significant.
- REQ-023 SHALL implement this register map, with reads combinational from WBs_ADR_i:
  - 0x00 LEVEL, RO: {24'h0, filt}.
  - 0x01 INT_EN, RW.
  - 0x02 INT_POL, RW.
  - 0x03 INT_STAT, RO/W1C.
  - 0x04 DB_LIMIT, RW.
  - 0x05 RAW, RO: {24'h0, sync1}.
  - Any other address: DEF_REG_VALUE.
- REQ-024 SHALL zero-extend all 8-bit registers to DATAWIDTH on read.
- REQ-025 SHALL take a DB_LIMIT change on the next cycle without resetting in-flight counters; a counter already >= the new limit updates filt on the next differing cycle.
- REQ-026 SHALL count a bit that toggles before reaching the limit as a glitch: its counter returns to 0 and filt is unchanged.

Reset
- REQ-027 SHALL, while WBs_RST_i=1 at a clock edge, set:
  - sync0, sync1, filt, filt_d, counters, INT_EN, INT_POL, INT_STAT: 0;
  - DB_LIMIT: DB_LIMIT_RST;
  - WBs_ACK_o, IRQ_o: 0.
- REQ-028 SHALL abort any bus cycle in flight on reset with no ack; the master must retry.
- REQ-029 SHALL NOT leave an interrupt pending after reset release, even if a pad is high, because INT_EN=0.

Configuration
- REQ-030 SHALL, with macro GPIO_IN_COND_DEBOUNCE_EN defined, implement debounce per REQ-013..014 and REQ-025..026.
- REQ-031 SHALL, without GPIO_IN_COND_DEBOUNCE_EN:
  - omit the counters;
  - update filt <= sync1 every cycle (latency E+2);
  - read DB_LIMIT as 0 and ignore writes to it.

Verification
- REQ-032 SHALL cover debounce: DB_LIMIT=4; pad bit0 0->1 held 10 cycles -> GPIO_IN_o[0]=1 after edge E+5, LEVEL reads 0x01.
- REQ-033 SHALL cover glitch rejection: DB_LIMIT=4; 3-cycle pulse on pad bit3 -> GPIO_IN_o unchanged, INT_STAT stays 0x00.
- REQ-034 SHALL cover the interrupt path:
  - INT_EN=0x81, INT_POL=0x01; pad bit0 rises, bit7 falls -> INT_STAT=0x81, then IRQ_o=1.
  - Write 0x01 to addr 0x03 -> INT_STAT=0x80, IRQ_o stays 1.
- REQ-035 SHALL cover set-versus-clear collision: W1C of bit2 in the same cycle that bit2 sets -> INT_STAT[2]=1.
- REQ-036 SHALL cover bus behaviour:
  - read addr 0x7F -> 32'hFAB_DEF_AC with one ack pulse;
  - write with WBs_BYTE_STB_i=4'b1110 to 0x01 -> INT_EN unchanged.
- REQ-037 SHALL cover reset mid-operation: assert WBs_RST_i during a debounce count and a pending IRQ -> all registers at reset values next cycle, IRQ_o=0, DB_LIMIT=0x04.
